// File: rtl/lfsr_gen_if.sv
// Handshake bundle for lfsr_gen: control from the master, state and status
// pulses back from the generator.
interface lfsr_gen_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic [WIDTH-1:0] count;
  logic             period_done;
  logic             lockup;
  logic             seed_err;

  modport master (
    output en, load, seed,
    input  q, sout, count, period_done, lockup, seed_err
  );

  modport slave (
    input  en, load, seed,
    output q, sout, count, period_done, lockup, seed_err
  );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, period tracking and
// zero-state lockup recovery.
module lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input logic        clk,
  input logic        rst,
  lfsr_gen_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be nonzero");
  end
  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be within 3..32");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             period_done_q, period_done_d;
  logic             lockup_q, lockup_d;
  logic             seed_err_q, seed_err_d;
  logic [WIDTH-1:0] next_state;

  always_comb begin
    if (MODE == 0) begin
      next_state = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    end else begin
      next_state = {q_q[WIDTH-2:0], 1'b0} ^ (q_q[WIDTH-1] ? TAPS : '0);
    end
  end

  always_comb begin
    q_d           = q_q;
    start_d       = start_q;
    count_d       = count_q;
    period_done_d = 1'b0;
    lockup_d      = 1'b0;
    seed_err_d    = 1'b0;
    if (bus.load) begin
      count_d = '0;
      if (bus.seed != '0) begin
        q_d     = bus.seed;
        start_d = bus.seed;
      end else begin
        // A zero seed would lock the register; fall back to 1 and flag it.
        q_d        = ONE;
        start_d    = ONE;
        seed_err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (q_q == '0) begin
        q_d      = SEED;
        start_d  = SEED;
        count_d  = '0;
        lockup_d = 1'b1;
      end else if (next_state == start_q) begin
        q_d           = next_state;
        count_d       = '0;
        period_done_d = 1'b1;
      end else begin
        q_d     = next_state;
        count_d = count_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q           <= SEED;
      start_q       <= SEED;
      count_q       <= '0;
      period_done_q <= 1'b0;
      lockup_q      <= 1'b0;
      seed_err_q    <= 1'b0;
    end else begin
      q_q           <= q_d;
      start_q       <= start_d;
      count_q       <= count_d;
      period_done_q <= period_done_d;
      lockup_q      <= lockup_d;
      seed_err_q    <= seed_err_d;
    end
  end

  assign bus.q           = q_q;
  assign bus.sout        = q_q[WIDTH-1];
  assign bus.count       = count_q;
  assign bus.period_done = period_done_q;
  assign bus.lockup      = lockup_q;
  assign bus.seed_err    = seed_err_q;

endmodule
